// File: rtl/inst_rom_if.sv
// Fetch and byte-loader signals of the instruction ROM, with one modport per side.
// Loader handshake: a byte moves on a rising clk edge where ld_valid && ld_ready;
// ld_byte and ld_last are only looked at in that cycle, and ld_valid may drop at any time.
interface inst_rom_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;

  modport master (
    output ce, addr, ld_valid, ld_byte, ld_last,
    input  inst, inst_valid, addr_err, ld_ready, ld_done
  );

  modport slave (
    input  ce, addr, ld_valid, ld_byte, ld_last,
    output inst, inst_valid, addr_err, ld_ready, ld_done
  );
endinterface

// File: rtl/inst_rom.sv
// Instruction memory: byte-serial little-endian loader fills the array after reset,
// then a one-cycle-latency registered fetch port serves the PC stage.
module inst_rom #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_rom_if.slave     bus,
  output logic          state_o
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // state_o: 0 = LOAD, 1 = READY
  typedef enum logic {S_LOAD = 1'b0, S_READY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [23:0]             part_q, part_d;
  logic [31:0]             inst_q;
  logic                    inst_valid_q, inst_valid_d;
  logic                    addr_err_q, addr_err_d;

  logic [31:0]             mem [WORDS];
  logic                    mem_we;
  logic [31:0]             word_asm;
  logic                    aligned;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  // Incoming byte lands above the bytes already collected; higher bytes stay zero for a short tail.
  always_comb begin
    word_asm = 32'h0;
    case (bcnt_q)
      2'd0:    word_asm = {24'h0, bus.ld_byte};
      2'd1:    word_asm = {16'h0, bus.ld_byte, part_q[7:0]};
      2'd2:    word_asm = {8'h0,  bus.ld_byte, part_q[15:0]};
      default: word_asm = {bus.ld_byte, part_q};
    endcase
  end

  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign in_range = ((bus.addr >> (DEPTH_LOG2 + 2)) == 32'h0);
  assign rd_idx   = bus.addr[DEPTH_LOG2+1:2];

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    bcnt_d       = bcnt_q;
    part_d       = part_q;
    mem_we       = 1'b0;
    inst_valid_d = 1'b0;
    addr_err_d   = 1'b0;

    if (state_q == S_LOAD && bus.ld_valid) begin
      if (bcnt_q == 2'd3 || bus.ld_last) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        bcnt_d = 2'd0;
        part_d = 24'h0;
        if (bus.ld_last || wptr_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = S_READY;
        end
      end else begin
        bcnt_d = bcnt_q + 2'd1;
        part_d = word_asm[23:0];
      end
    end

    if (state_q == S_READY && bus.ce) begin
      if (aligned && in_range) begin
        inst_valid_d = 1'b1;
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      wptr_q       <= '0;
      bcnt_q       <= 2'd0;
      part_q       <= 24'h0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      bcnt_q       <= bcnt_d;
      part_q       <= part_d;
      inst_q       <= inst_valid_d ? mem[rd_idx] : NOP_INST;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Array is deliberately not reset so words survive a reload that stops short.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wptr_q] <= word_asm;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.ld_ready   = (state_q == S_LOAD);
  assign bus.ld_done    = (state_q == S_READY);
  assign state_o        = state_q;

endmodule
